aurora_tx_packer: RTL and testbench

Upstream framing stage for the Aurora transmit path. Captures one multi-channel sample set per `SAMPLE_STB`, packs it into a fixed-length burst of 32-bit words (header, packed channel data, optional checksum), and writes the burst into the TX engine's write-side FIFO through `TX_DATA`/`TX_CLK_EN`. Runs entirely in the `TX_CLOCK` domain and drops whole frames, never partial ones, when it cannot accept them.

---
 rtl/aurora_tx_packer.sv | 165 ++++++++++++++++
 tb/tb_aurora_tx_packer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_tx_packer.sv
// aurora_tx_packer
//
// Framing stage ahead of the Aurora TX FIFO. Each qualified sample strobe
// (SAMPLE_STB && ENABLE) is latched and written out as one contiguous burst:
// a header word, N_CH/2 packed channel words and, when built with
// AURORA_TX_PACKER_CHECKSUM_EN, a trailing 32-bit additive checksum. Frames
// that cannot be accepted (FIFO_FULL at the strobe, or block busy) are dropped
// whole and counted.
//
// Optional feature macro: AURORA_TX_PACKER_CHECKSUM_EN (checksum trailer word).
//
// Ports:
//   TX_CLOCK    in   clock, rising edge (FIFO write clock)
//   RESET_N     in   asynchronous active-low reset
//   ENABLE      in   gates acceptance of new strobes
//   SAMPLE_STB  in   one-cycle sample strobe
//   SAMPLE_DATA in   16*N_CH channel bits, channel i at [16i+15:16i]
//   FIFO_FULL   in   FIFO programmable-full, checked only at frame start
//   TX_DATA     out  word to FIFO din, holds while TX_CLK_EN is low
//   TX_CLK_EN   out  FIFO wr_en
//   SEQ_NUM     out  sequence number of the latest qualified strobe
//   DROP_CNT    out  dropped-frame count, saturating
//   BUSY        out  high while a frame is being written
//
// N_CH must be even, 2..64.

module aurora_tx_packer #(
  parameter int unsigned N_CH = 8
) (
  input  logic                TX_CLOCK,
  input  logic                RESET_N,
  input  logic                ENABLE,
  input  logic                SAMPLE_STB,
  input  logic [16*N_CH-1:0]  SAMPLE_DATA,
  input  logic                FIFO_FULL,
  output logic [31:0]         TX_DATA,
  output logic                TX_CLK_EN,
  output logic [15:0]         SEQ_NUM,
  output logic [15:0]         DROP_CNT,
  output logic                BUSY
);

  localparam int unsigned NWords = N_CH / 2;
  localparam int unsigned IdxW   = (NWords > 1) ? $clog2(NWords) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NWords - 1);
  localparam logic [7:0]      NChByte = 8'(N_CH);

  // State names the word currently presented on TX_DATA.
`ifdef AURORA_TX_PACKER_CHECKSUM_EN
  typedef enum logic [1:0] {StIdle, StHeader, StData, StCksum} state_e;
`else
  typedef enum logic [1:0] {StIdle, StHeader, StData} state_e;
`endif

  state_e              state_q;
  logic [16*N_CH-1:0]  sample_q;
  logic [IdxW-1:0]     k_q;
  logic [31:0]         tx_data_q;
  logic                tx_en_q;
  logic [15:0]         seq_q;
  logic [15:0]         drop_q;
  logic                busy_q;
`ifdef AURORA_TX_PACKER_CHECKSUM_EN
  logic [31:0]         cksum_q;
`endif

  logic        counted;
  logic        accept;
  logic        drop;
  logic [31:0] header_w;
  logic [31:0] cur_word;

  assign counted  = SAMPLE_STB && ENABLE;
  assign accept   = counted && (state_q == StIdle) && !FIFO_FULL;
  assign drop     = counted && !accept;
  assign header_w = {8'hA5, NChByte, seq_q + 16'd1};
  // Latched samples are consumed from the bottom; the low 32 bits always
  // hold the next pair (even channel goes to the upper half).
  assign cur_word = {sample_q[15:0], sample_q[31:16]};

  always_ff @(posedge TX_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      sample_q  <= '0;
      k_q       <= '0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      seq_q     <= '0;
      drop_q    <= '0;
      busy_q    <= 1'b0;
`ifdef AURORA_TX_PACKER_CHECKSUM_EN
      cksum_q   <= '0;
`endif
    end else begin
      if (counted) begin
        seq_q <= seq_q + 16'd1;
      end
      if (drop && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            sample_q  <= SAMPLE_DATA;
            tx_data_q <= header_w;
            tx_en_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= StHeader;
`ifdef AURORA_TX_PACKER_CHECKSUM_EN
            cksum_q   <= header_w;
`endif
          end
        end
        StHeader: begin
          tx_data_q <= cur_word;
          sample_q  <= sample_q >> 32;
          k_q       <= '0;
          state_q   <= StData;
`ifdef AURORA_TX_PACKER_CHECKSUM_EN
          cksum_q   <= cksum_q + cur_word;
`endif
        end
        StData: begin
          if (k_q == LastIdx) begin
`ifdef AURORA_TX_PACKER_CHECKSUM_EN
            tx_data_q <= cksum_q;
            state_q   <= StCksum;
`else
            tx_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= StIdle;
`endif
          end else begin
            tx_data_q <= cur_word;
            sample_q  <= sample_q >> 32;
            k_q       <= k_q + 1'b1;
`ifdef AURORA_TX_PACKER_CHECKSUM_EN
            cksum_q   <= cksum_q + cur_word;
`endif
          end
        end
`ifdef AURORA_TX_PACKER_CHECKSUM_EN
        StCksum: begin
          tx_en_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
`endif
        default: begin
          tx_en_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign TX_DATA   = tx_data_q;
  assign TX_CLK_EN = tx_en_q;
  assign SEQ_NUM   = seq_q;
  assign DROP_CNT  = drop_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_aurora_tx_packer.sv
module tb_aurora_tx_packer;

  localparam int NCH = 8;
  localparam int DW  = 16 * NCH;
`ifdef AURORA_TX_PACKER_CHECKSUM_EN
  localparam int FrameLen = NCH / 2 + 2;
`else
  localparam int FrameLen = NCH / 2 + 1;
`endif

  logic          TX_CLOCK = 1'b0;
  logic          RESET_N  = 1'b0;
  logic          ENABLE   = 1'b1;
  logic          SAMPLE_STB = 1'b0;
  logic [DW-1:0] SAMPLE_DATA = '0;
  logic          FIFO_FULL = 1'b0;
  logic [31:0]   TX_DATA;
  logic          TX_CLK_EN;
  logic [15:0]   SEQ_NUM;
  logic [15:0]   DROP_CNT;
  logic          BUSY;

  aurora_tx_packer #(.N_CH(NCH)) u_dut (
    .TX_CLOCK    (TX_CLOCK),
    .RESET_N     (RESET_N),
    .ENABLE      (ENABLE),
    .SAMPLE_STB  (SAMPLE_STB),
    .SAMPLE_DATA (SAMPLE_DATA),
    .FIFO_FULL   (FIFO_FULL),
    .TX_DATA     (TX_DATA),
    .TX_CLK_EN   (TX_CLK_EN),
    .SEQ_NUM     (SEQ_NUM),
    .DROP_CNT    (DROP_CNT),
    .BUSY        (BUSY)
  );

  always #5 TX_CLOCK = ~TX_CLOCK;

  int n_checks = 0;
  int n_pass   = 0;
  int n_wr     = 0;
  logic [31:0] sb[$];
  logic [31:0] fw[FrameLen];
  logic [15:0] exp_seq;
  logic [15:0] exp_drop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Scoreboard consumer: every written word is compared to the next expected.
  always @(negedge TX_CLOCK) begin
    if (RESET_N && TX_CLK_EN) begin
      n_wr <= n_wr + 1;
      if (sb.size() != 0) check("tx_word", TX_DATA, sb.pop_front());
    end
  end

  task automatic build_frame(input logic [DW-1:0] d, input logic [15:0] seq);
    logic [31:0] sum;
    fw[0] = {8'hA5, 8'(NCH), seq};
    sum = fw[0];
    for (int k = 0; k < NCH / 2; k++) begin
      fw[k+1] = {d[32*k +: 16], d[32*k+16 +: 16]};
      sum = sum + fw[k+1];
    end
`ifdef AURORA_TX_PACKER_CHECKSUM_EN
    fw[NCH/2+1] = sum;
`endif
  endtask

  // Called at a negedge; returns at the negedge of the cycle after the strobe.
  task automatic pulse(input logic [DW-1:0] d);
    SAMPLE_DATA = d;
    SAMPLE_STB  = 1'b1;
    @(negedge TX_CLOCK);
    SAMPLE_STB  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge TX_CLOCK);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    idle(2);
    sb.delete();
    exp_seq  = '0;
    exp_drop = '0;
    RESET_N  = 1'b1;
    idle(1);
  endtask

  // Accepted frame: push expectations, strobe, then check contiguous wr_en.
  task automatic accept_frame(input logic [DW-1:0] d);
    exp_seq = exp_seq + 16'd1;
    build_frame(d, exp_seq);
    for (int i = 0; i < FrameLen; i++) sb.push_back(fw[i]);
    pulse(d);
    check("busy_rise", 32'(BUSY), 32'd1);
    for (int i = 0; i < FrameLen; i++) begin
      check("wr_en_contig", 32'(TX_CLK_EN), 32'd1);
      @(negedge TX_CLOCK);
    end
    check("wr_en_end", 32'(TX_CLK_EN), 32'd0);
    check("busy_fall", 32'(BUSY), 32'd0);
  endtask

  logic [DW-1:0] d_inc, d_alt, d_ones;
  int base;

  initial begin
    for (int i = 0; i < NCH; i++) begin
      d_inc[16*i +: 16] = 16'(i + 1);
      d_alt[16*i +: 16] = 16'h1000 * 16'(i) + 16'h0B0B;
    end
    d_ones = '1;

    // Reset values
    idle(2);
    check("rst_tx_data", TX_DATA, 32'd0);
    check("rst_wr_en", 32'(TX_CLK_EN), 32'd0);
    check("rst_seq", 32'(SEQ_NUM), 32'd0);
    check("rst_drop", 32'(DROP_CNT), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    do_reset();

    // Single frame
    base = n_wr;
    accept_frame(d_inc);
    idle(3);
    check("single_count", 32'(n_wr - base), 32'(FrameLen));
    check("single_sb_empty", 32'(sb.size()), 32'd0);
    check("single_seq", 32'(SEQ_NUM), 32'd1);
    check("single_drop", 32'(DROP_CNT), 32'd0);

    // Strobe while busy (two cycles after the first)
    do_reset();
    base = n_wr;
    exp_seq = exp_seq + 16'd1;
    build_frame(d_inc, exp_seq);
    for (int i = 0; i < FrameLen; i++) sb.push_back(fw[i]);
    pulse(d_inc);
    idle(1);
    exp_seq  = exp_seq + 16'd1;
    exp_drop = exp_drop + 16'd1;
    pulse(d_alt);
    idle(FrameLen + 2);
    check("busy_count", 32'(n_wr - base), 32'(FrameLen));
    check("busy_seq", 32'(SEQ_NUM), 32'(exp_seq));
    check("busy_drop", 32'(DROP_CNT), 32'(exp_drop));
    accept_frame(d_alt);
    idle(2);
    check("busy_next_count", 32'(n_wr - base), 32'(2 * FrameLen));
    check("busy_next_seq", 32'(SEQ_NUM), 32'd3);

    // FIFO full at strobe
    do_reset();
    base = n_wr;
    FIFO_FULL = 1'b1;
    exp_seq  = exp_seq + 16'd1;
    exp_drop = exp_drop + 16'd1;
    pulse(d_inc);
    FIFO_FULL = 1'b0;
    idle(FrameLen + 2);
    check("full_count", 32'(n_wr - base), 32'd0);
    check("full_seq", 32'(SEQ_NUM), 32'd1);
    check("full_drop", 32'(DROP_CNT), 32'd1);
    check("full_busy", 32'(BUSY), 32'd0);
    accept_frame(d_inc);
    idle(2);
    check("full_after_count", 32'(n_wr - base), 32'(FrameLen));

    // Checksum wrap with all channels 0xFFFF
    accept_frame(d_ones);
    idle(2);
    check("ones_sb_empty", 32'(sb.size()), 32'd0);

    // ENABLE low: strobe ignored
    base = n_wr;
    ENABLE = 1'b0;
    pulse(d_alt);
    ENABLE = 1'b1;
    idle(FrameLen + 2);
    check("dis_seq", 32'(SEQ_NUM), 32'(exp_seq));
    check("dis_count", 32'(n_wr - base), 32'd0);

    // Reset during the third data word
    do_reset();
    base = n_wr;
    exp_seq = exp_seq + 16'd1;
    build_frame(d_alt, exp_seq);
    for (int i = 0; i < 4; i++) sb.push_back(fw[i]);
    pulse(d_alt);
    idle(3);
    #1 RESET_N = 1'b0;
    #1;
    check("arst_tx_data", TX_DATA, 32'd0);
    check("arst_wr_en", 32'(TX_CLK_EN), 32'd0);
    check("arst_seq", 32'(SEQ_NUM), 32'd0);
    check("arst_busy", 32'(BUSY), 32'd0);
    idle(2);
    RESET_N = 1'b1;
    idle(FrameLen + 2);
    check("arst_count", 32'(n_wr - base), 32'd4);
    check("arst_sb_empty", 32'(sb.size()), 32'd0);

    // Sequence wrap and drop saturation: every cycle a dropped strobe
    do_reset();
    FIFO_FULL  = 1'b1;
    SAMPLE_STB = 1'b1;
    idle(65535);
    check("wrap_seq_max", 32'(SEQ_NUM), 32'h0000FFFF);
    check("sat_drop_max", 32'(DROP_CNT), 32'h0000FFFF);
    idle(1);
    check("wrap_seq_zero", 32'(SEQ_NUM), 32'd0);
    check("sat_drop_hold", 32'(DROP_CNT), 32'h0000FFFF);
    idle(3);
    SAMPLE_STB = 1'b0;
    FIFO_FULL  = 1'b0;
    idle(1);
    check("wrap_seq_three", 32'(SEQ_NUM), 32'd3);
    check("sat_drop_final", 32'(DROP_CNT), 32'h0000FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
